comp_seq: RTL and testbench

- Multi-cycle, parametrised magnitude comparator. Successor to the combinational comparator function.
- Compares two busWidth operands one chunkWidth slice per clock, MSB slice first, with early termination on the first differing slice.
- Adds a signed/unsigned mode and a start/busy/done handshake so wide operands meet timing in the datapath.
- Result uses the team's existing 3-bit op encoding, so downstream decoders are unchanged.

---
 rtl/comp_seq.sv | 106 ++++++++++
 tb/tb_comp_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/comp_seq.sv
// comp_seq: multi-cycle magnitude comparator.
// Compares a and b one chunkWidth slice per clock, starting with the MSB
// slice, and stops at the first slice that differs.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   start       - request, sampled only while busy=0
//   a, b        - operands, captured on accepted start
//   signedMode  - 1 = two's-complement compare, 0 = unsigned
//   busy        - compare in progress
//   done        - one-cycle pulse when op becomes valid
//   op          - 100 a>b, 010 a==b, 001 a<b, 000 no result
module comp_seq #(
  parameter int busWidth   = 16,
  parameter int chunkWidth = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [busWidth-1:0] a,
  input  logic [busWidth-1:0] b,
  input  logic                signedMode,
  output logic                busy,
  output logic                done,
  output logic [3:1]          op
);
  localparam int NCHUNK = busWidth / chunkWidth;
  localparam int JW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [JW-1:0] LAST = JW'(NCHUNK - 1);
  localparam logic [busWidth-1:0] MSB_MASK = busWidth'(1) << (busWidth - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CMP  = 1'b1;

  generate
    if (chunkWidth < 1 || (busWidth % chunkWidth) != 0) begin : g_bad_width
      $error("comp_seq: busWidth must be a non-zero multiple of chunkWidth");
    end
  endgenerate

  logic [0:0]    state;
  logic [JW-1:0] j;
  // Operands held as MSB-first slices; slice NCHUNK-1 is the top slice.
  logic [NCHUNK-1:0][chunkWidth-1:0] a_q, b_q;
  logic [chunkWidth-1:0] sa, sb;
  logic [busWidth-1:0]   flip;

  // Flipping the sign bit of both operands maps two's-complement order onto
  // unsigned order. The sign bit lives in the top slice, so doing it once at
  // capture is equivalent to flipping it whenever slice 0 is compared, and the
  // mode itself need not be kept.
  assign flip = signedMode ? MSB_MASK : '0;

  // Slice j counts from the top: j=0 selects the MSB slice.
  always_comb begin
    sa = '0;
    sb = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (j == JW'(i)) begin
        sa = a_q[NCHUNK-1-i];
        sb = b_q[NCHUNK-1-i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      op    <= 3'b000;
      j     <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a ^ flip;
            b_q   <= b ^ flip;
            busy  <= 1'b1;
            op    <= 3'b000;
            j     <= '0;
            state <= CMP;
          end
        end
        CMP: begin
          if (sa != sb) begin
            op    <= (sa > sb) ? 3'b100 : 3'b001;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (j == LAST) begin
            op    <= 3'b010;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            j <= j + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_comp_seq.sv
// Scoreboard bench for comp_seq: stimulus pushes {expected op, expected done
// cycle}; per-DUT monitors pop and compare on every done pulse.
module tb_comp_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 16-bit / 4-bit-chunk instance
  logic        start16, s16, busy16, done16;
  logic [15:0] a16, b16;
  logic [3:1]  op16;
  // 8-bit / 8-bit-chunk instance (single slice)
  logic        start8, s8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [3:1]  op8;

  comp_seq #(.busWidth(16), .chunkWidth(4)) u16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .signedMode(s16), .busy(busy16), .done(done16), .op(op16));

  comp_seq #(.busWidth(8), .chunkWidth(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .signedMode(s8), .busy(busy8), .done(done8), .op(op8));

  typedef struct packed {
    logic [2:0] op;
    int         cyc;
  } exp_t;

  exp_t q16[$];
  exp_t q8[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic mon16();
    exp_t e;
    forever begin
      @(negedge clk);
      if (done16) begin
        if (q16.size() == 0) begin
          chk("u16_unexpected_done", 1, 0);
        end else begin
          e = q16.pop_front();
          chk("u16_op", int'(op16), int'(e.op));
          chk("u16_done_cycle", cyc, e.cyc);
        end
      end
    end
  endtask

  task automatic mon8();
    exp_t e;
    forever begin
      @(negedge clk);
      if (done8) begin
        if (q8.size() == 0) begin
          chk("u8_unexpected_done", 1, 0);
        end else begin
          e = q8.pop_front();
          chk("u8_op", int'(op8), int'(e.op));
          chk("u8_done_cycle", cyc, e.cyc);
        end
      end
    end
  endtask

  // Issue one start on u16; lat = expected cycles from accepting edge to done.
  task automatic issue16(input logic [15:0] av, input logic [15:0] bv,
                         input logic s, input logic [2:0] eop, input int lat,
                         input logic push);
    exp_t e;
    @(negedge clk);
    a16 = av; b16 = bv; s16 = s; start16 = 1'b1;
    @(posedge clk);
    #1;
    start16 = 1'b0;
    e.op  = eop;
    e.cyc = cyc + lat;
    if (push) q16.push_back(e);
    chk("u16_busy_after_start", int'(busy16), 1);
  endtask

  // Count busy negedges until u16 goes idle; a blown budget is a failure.
  task automatic wait_idle16(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy16) return;
      n++;
    end
    chk("u16_idle_timeout", 1, 0);
  endtask

  initial begin
    int n;
    int acc;
    exp_t e;
    rst = 1'b1;
    start16 = 1'b0; a16 = '0; b16 = '0; s16 = 1'b0;
    start8  = 1'b0; a8  = '0; b8  = '0; s8  = 1'b0;
    fork
      mon16();
      mon8();
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy16), 0);
    chk("rst_done", int'(done16), 0);
    chk("rst_op", int'(op16), 0);
    chk("rst_op8", int'(op8), 0);
    @(negedge clk);
    rst = 1'b0;

    // Equal operands: full 4-slice walk, result holds afterwards.
    issue16(16'h1234, 16'h1234, 1'b0, 3'b010, 4, 1'b1);
    wait_idle16(n);
    chk("eq_busy_cycles", n, 4);
    repeat (3) @(negedge clk);
    chk("eq_op_hold", int'(op16), 3'b010);
    chk("eq_done_low", int'(done16), 0);

    // Difference only in the last slice.
    issue16(16'h0001, 16'h0008, 1'b0, 3'b001, 4, 1'b1);
    wait_idle16(n);

    // Top-slice difference, unsigned vs signed.
    issue16(16'hA000, 16'h1000, 1'b0, 3'b100, 1, 1'b1);
    wait_idle16(n);
    issue16(16'hA000, 16'h1000, 1'b1, 3'b001, 1, 1'b1);
    wait_idle16(n);
    chk("signed_busy_cycles", n, 1);

    // Second start while busy (with new operands) is ignored.
    issue16(16'h00F0, 16'h00E0, 1'b0, 3'b100, 3, 1'b1);
    @(negedge clk);
    a16 = '0; b16 = '0; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    wait_idle16(n);
    repeat (4) @(negedge clk);
    chk("ignored_start_idle", int'(busy16), 0);

    // Reset mid-compare: abandoned, no done pulse.
    issue16(16'h0001, 16'h0002, 1'b0, 3'b001, 4, 1'b0);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy", int'(busy16), 0);
    chk("midrst_op", int'(op16), 0);
    chk("midrst_done", int'(done16), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    issue16(16'h0005, 16'h0005, 1'b0, 3'b010, 4, 1'b1);
    wait_idle16(n);
    chk("after_rst_busy_cycles", n, 4);

    // start held high on both instances: done every 2 cycles, latency 1.
    @(negedge clk);
    a16 = 16'hFFFF; b16 = 16'h0000; s16 = 1'b1; start16 = 1'b1;
    a8  = 8'hFF;    b8  = 8'h00;    s8  = 1'b1; start8  = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    for (int k = 0; k < 3; k++) begin
      e.op  = 3'b001;
      e.cyc = acc + 1 + 2 * k;
      q16.push_back(e);
      q8.push_back(e);
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    start16 = 1'b0;
    start8  = 1'b0;
    repeat (6) @(negedge clk);

    chk("q16_drained", q16.size(), 0);
    chk("q8_drained", q8.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
